// File: rtl/sram_mac_pkg.sv
// rtl/sram_mac_pkg.sv - controller state and mode encodings shared by the sram_mac_engine files
package sram_mac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic MODE_PROD = 1'b0;
    localparam logic MODE_DOT  = 1'b1;

endpackage

// File: rtl/mac_mul_acc.sv
// rtl/mac_mul_acc.sv - registered multiply with last-flagged dot-product accumulation
// DCIM_SIGNED_EN selects two's-complement operands and sign extension of the result.
module mac_mul_acc
    import sram_mac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int PROD_W = 2 * DATA_W,
    parameter int ACC_W  = PROD_W + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              mode,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [DATA_W-1:0] w,
    input  logic [DATA_W-1:0] act,
    output logic              out_valid,
    output logic [ACC_W-1:0]  out_data
);

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  prod_ext;
    logic [ACC_W-1:0]  acc;

`ifdef DCIM_SIGNED_EN
    logic signed [PROD_W-1:0] w_ext;
    logic signed [PROD_W-1:0] act_ext;
    assign w_ext    = PROD_W'($signed(w));
    assign act_ext  = PROD_W'($signed(act));
    assign prod     = w_ext * act_ext;
    assign prod_ext = ACC_W'($signed(prod));
`else
    logic [PROD_W-1:0] w_ext;
    logic [PROD_W-1:0] act_ext;
    assign w_ext    = PROD_W'(w);
    assign act_ext  = PROD_W'(act);
    assign prod     = w_ext * act_ext;
    assign prod_ext = ACC_W'(prod);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (clr) begin
                acc <= '0;
            end
            if (en) begin
                if (!in_valid) begin
                    out_valid <= 1'b0;
                end else if (mode == MODE_DOT) begin
                    // The last beat emits the full sum and restarts the accumulator in the same edge.
                    if (in_last) begin
                        out_data  <= acc + prod_ext;
                        out_valid <= 1'b1;
                        acc       <= '0;
                    end else begin
                        acc       <= acc + prod_ext;
                        out_valid <= 1'b0;
                    end
                end else begin
                    out_data  <= prod_ext;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sram_mac_engine.sv
// rtl/sram_mac_engine.sv - loads weights into an external SRAM, then streams activations as products or dot products
// Define DCIM_SIGNED_EN for two's-complement operands and sign-extended results.
module sram_mac_engine
    import sram_mac_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int PROD_W = 2 * DATA_W,
    parameter int ACC_W  = PROD_W + ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              init_start,
    input  logic              mode,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  out_data,
    output logic              init_done,
    output logic              sram_ce_n,
    output logic              sram_we_n,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic              mode_q, mode_pend;
    logic              en, accept, acc_clr;
    logic              s1_valid, s1_last;
    logic [DATA_W-1:0] s1_act;
    logic              s2_valid, s2_last;
    logic [DATA_W-1:0] s2_act, s2_w;

    assign en     = !out_valid || out_ready;
    assign accept = in_valid && in_ready;

    always_comb begin
        state_nx   = state;
        in_ready   = 1'b0;
        init_done  = 1'b0;
        acc_clr    = 1'b0;
        sram_ce_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_addr  = '0;
        sram_wdata = '0;
        case (state)
            IDLE: begin
                if (init_start) state_nx = LOAD;
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sram_ce_n  = 1'b0;
                    sram_we_n  = 1'b0;
                    sram_addr  = wr_ptr;
                    sram_wdata = in_data;
                    if (wr_ptr == LAST_ADDR) begin
                        state_nx = RUN;
                        acc_clr  = 1'b1;
                    end
                end
            end
            RUN: begin
                init_done = 1'b1;
                if (init_start) begin
                    state_nx = DRAIN;
                end else begin
                    in_ready = en;
                    if (in_valid && en) begin
                        sram_ce_n = 1'b0;
                        sram_addr = rd_ptr;
                    end
                end
            end
            DRAIN: begin
                // Beats already in flight finish; any partial sum is dropped on the way back to LOAD.
                if (!s1_valid && !s2_valid && !out_valid) begin
                    state_nx = LOAD;
                    acc_clr  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            mode_q    <= MODE_PROD;
            mode_pend <= MODE_PROD;
            s1_valid  <= 1'b0;
            s1_last   <= 1'b0;
            s1_act    <= '0;
            s2_valid  <= 1'b0;
            s2_last   <= 1'b0;
            s2_act    <= '0;
            s2_w      <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && init_start) begin
                mode_q <= mode;
                wr_ptr <= '0;
            end
            // The new mode must not reach beats still draining from the previous run.
            if (state == RUN && init_start) mode_pend <= mode;
            if (state == DRAIN && state_nx == LOAD) begin
                mode_q <= mode_pend;
                wr_ptr <= '0;
            end
            if (state == LOAD && accept) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
                if (wr_ptr == LAST_ADDR) rd_ptr <= '0;
            end
            if (state == RUN && accept) rd_ptr <= rd_ptr + ADDR_W'(1);
            if (en) begin
                s1_valid <= (state == RUN) && accept;
                s1_act   <= in_data;
                s1_last  <= (rd_ptr == LAST_ADDR);
                s2_valid <= s1_valid;
                s2_last  <= s1_last;
                s2_act   <= s1_act;
                s2_w     <= sram_rdata;
            end
        end
    end

    mac_mul_acc #(
        .DATA_W (DATA_W),
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (acc_clr),
        .mode      (mode_q),
        .in_valid  (s2_valid),
        .in_last   (s2_last),
        .w         (s2_w),
        .act       (s2_act),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

endmodule

// File: tb/tb_sram_mac_engine.sv
// tb/tb_sram_mac_engine.sv - randomized bench for sram_mac_engine with a behavioural SRAM and reference model
module tb_sram_mac_engine;

    localparam int DEPTH = 16;

`ifdef DCIM_SIGNED_EN
    localparam logic [19:0] FF_PROD = 20'd1;
    localparam logic [19:0] MIN_DOT = 20'd788480;
`else
    localparam logic [19:0] FF_PROD = 20'd65025;
    localparam logic [19:0] MIN_DOT = 20'd260096;
`endif

    logic        clk = 1'b0, rst_n = 1'b1, init_start = 1'b0, mode = 1'b0;
    logic        in_valid = 1'b0, out_ready = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_ready, out_valid, init_done, sram_ce_n, sram_we_n;
    logic [19:0] out_data;
    logic [3:0]  sram_addr;
    logic [7:0]  sram_wdata;
    logic [7:0]  sram_rdata = '0;
    logic [7:0]  mem [DEPTH];

    int          n_vec = 0, n_err = 0, cyc = 0, bp_mode = 0;
    bit          gaps = 1'b0, lat_chk = 1'b0, prev_stall = 1'b0;
    logic [19:0] prev_data;

    int          m_phase = 0, m_wcnt = 0, m_rcnt = 0;
    logic        m_mode = 1'b0;
    logic [19:0] m_acc = '0;
    logic [7:0]  m_w [DEPTH];
    logic [19:0] exp_v[$];
    int          exp_e[$];
    logic [19:0] got_q[$];
    logic        acc_b;
    logic [19:0] p_t;
    int          e_t;

    always #5 clk = ~clk;

    sram_mac_engine dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .init_start (init_start),
        .mode       (mode),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .init_done  (init_done),
        .sram_ce_n  (sram_ce_n),
        .sram_we_n  (sram_we_n),
        .sram_addr  (sram_addr),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!sram_ce_n) begin
            if (!sram_we_n) mem[sram_addr] <= sram_wdata;
            else            sram_rdata     <= mem[sram_addr];
        end
    end

    function automatic logic [19:0] prod(input logic [7:0] w, input logic [7:0] a);
        int p;
`ifdef DCIM_SIGNED_EN
        p = int'($signed(w)) * int'($signed(a));
`else
        p = int'(w) * int'(a);
`endif
        return p[19:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_init_done"}, init_done, 0);
        chk({tag, "_ce_n"}, sram_ce_n, 1);
        chk({tag, "_we_n"}, sram_we_n, 1);
        chk({tag, "_addr"}, sram_addr, 0);
        chk({tag, "_wdata"}, sram_wdata, 0);
    endtask

    // Reference model and per-cycle compare; handshakes seen here complete on the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_phase = 0;
            m_acc = '0;
            prev_stall = 1'b0;
            exp_v.delete();
            exp_e.delete();
        end else begin
            acc_b = in_valid && in_ready;
            chk("init_done", init_done, m_phase == 2);
            if (m_phase == 0) begin
                chk("idle_in_ready", in_ready, 0);
                chk("idle_ce_n", sram_ce_n, 1);
            end
            if (m_phase == 1) begin
                chk("load_ce_n", sram_ce_n, !acc_b);
                if (acc_b) begin
                    chk("load_we_n", sram_we_n, 0);
                    chk("load_addr", sram_addr, m_wcnt);
                    chk("load_wdata", sram_wdata, in_data);
                end
            end
            if (m_phase == 2) begin
                chk("run_in_ready", in_ready, (!out_valid || out_ready) && !init_start);
                chk("run_ce_n", sram_ce_n, !acc_b);
                if (acc_b) begin
                    chk("run_we_n", sram_we_n, 1);
                    chk("run_addr", sram_addr, m_rcnt);
                end
            end
            if (prev_stall && out_valid) chk("stall_hold", out_data, prev_data);
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (exp_v.size() == 0) begin
                    chk("spurious_out", out_valid, 0);
                end else begin
                    chk("out_data", out_data, exp_v.pop_front());
                    e_t = exp_e.pop_front();
                    if (lat_chk) chk("latency", cyc - e_t, 2);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            if (acc_b && m_phase == 1) begin
                m_w[m_wcnt] = in_data;
                m_wcnt++;
                if (m_wcnt == DEPTH) begin
                    m_phase = 2;
                    m_rcnt  = 0;
                    m_acc   = '0;
                end
            end else if (acc_b && m_phase == 2) begin
                p_t = prod(m_w[m_rcnt], in_data);
                if (!m_mode) begin
                    exp_v.push_back(p_t);
                    exp_e.push_back(cyc + 1);
                end else begin
                    m_acc = m_acc + p_t;
                    if (m_rcnt == DEPTH - 1) begin
                        exp_v.push_back(m_acc);
                        exp_e.push_back(cyc + 1);
                        m_acc = '0;
                    end
                end
                m_rcnt = (m_rcnt + 1) % DEPTH;
            end
            if (init_start && (m_phase == 0 || m_phase == 2)) begin
                m_phase = 1;
                m_mode  = mode;
                m_wcnt  = 0;
                m_acc   = '0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (bp_mode == 0)      out_ready = 1'b1;
            else if (bp_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
            else                   out_ready = 1'b0;
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        int t;
        bit hs;
        if (gaps) begin
            while ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_data  = 8'($urandom);
                step();
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        t = 0;
        do begin
            @(negedge clk);
            hs = in_ready;
            step();
            t++;
        end while (!hs && t < 200);
        if (!hs) chk("send_timeout", hs, 1);
    endtask

    task automatic init(input logic m);
        in_valid   = 1'b0;
        init_start = 1'b1;
        mode       = m;
        step();
        init_start = 1'b0;
    endtask

    // kind: 0 = i+1 ramp, 1 = constant c, 2 = random
    task automatic stream(input int n, input int kind, input logic [7:0] c);
        for (int i = 0; i < n; i++)
            send(kind == 0 ? 8'(i + 1) : (kind == 1 ? c : 8'($urandom)));
        in_valid = 1'b0;
    endtask

    task automatic wait_idle;
        int t;
        t = 0;
        while ((exp_v.size() != 0 || out_valid) && t < 400) begin
            step();
            t++;
        end
        chk("idle_timeout", exp_v.size() != 0 || out_valid, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset("por");
        step();
        rst_n = 1'b1;

        // Mode 0 ramp weights times 3, latency checked
        got_q.delete();
        init(1'b0);
        stream(DEPTH, 0, 8'd0);
        lat_chk = 1'b1;
        stream(DEPTH, 1, 8'd3);
        wait_idle();
        lat_chk = 1'b0;
        chk("t1_count", got_q.size(), 16);
        if (got_q.size() == 16)
            for (int i = 0; i < 16; i++) chk("t1_lit", got_q[i], 3 * (i + 1));

        // Mode 1 dot products
        got_q.delete();
        init(1'b1);
        stream(DEPTH, 0, 8'd0);
        stream(DEPTH, 1, 8'd2);
        wait_idle();
        stream(DEPTH, 1, 8'd1);
        wait_idle();
        chk("t2_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t2_sum272", got_q[0], 272);
            chk("t2_sum136", got_q[1], 136);
        end

        // Mode 0 with a 5-cycle output stall mid-stream
        got_q.delete();
        init(1'b0);
        stream(DEPTH, 0, 8'd0);
        fork
            stream(DEPTH, 1, 8'd5);
            begin
                repeat (8) @(posedge clk);
                #1 bp_mode = 2;
                repeat (5) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 0);
                    chk("stall_ce_n", sram_ce_n, 1);
                    @(posedge clk);
                end
                #1 bp_mode = 0;
            end
        join
        wait_idle();
        chk("t3_count", got_q.size(), 16);
        if (got_q.size() == 16)
            for (int i = 0; i < 16; i++) chk("t3_lit", got_q[i], 5 * (i + 1));

        // Read pointer wrap
        got_q.delete();
        init(1'b0);
        stream(DEPTH, 0, 8'd0);
        stream(20, 1, 8'd1);
        wait_idle();
        chk("t4_count", got_q.size(), 20);
        if (got_q.size() == 20)
            for (int i = 16; i < 20; i++) chk("t4_wrap", got_q[i], i - 15);

        // Reset in the middle of a load, then a full reload
        init(1'b0);
        for (int i = 0; i < 7; i++) send(8'(i + 1));
        rst_n = 1'b0;
        #1;
        check_reset("abort");
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        got_q.delete();
        init(1'b1);
        stream(DEPTH, 0, 8'd0);
        stream(DEPTH, 1, 8'd2);
        wait_idle();
        chk("t5_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("t5_sum", got_q[0], 272);

        // init_start during a partial dot product
        got_q.delete();
        stream(5, 1, 8'd1);
        init(1'b1);
        repeat (10) step();
        chk("t6_no_out", got_q.size(), 0);
        stream(DEPTH, 0, 8'd0);
        stream(DEPTH, 1, 8'd3);
        wait_idle();
        chk("t6_count", got_q.size(), 1);
        if (got_q.size() == 1) chk("t6_sum", got_q[0], 408);

        // Operand extremes
        got_q.delete();
        init(1'b0);
        stream(DEPTH, 1, 8'hFF);
        stream(1, 1, 8'hFF);
        wait_idle();
        init(1'b1);
        stream(DEPTH, 1, 8'h80);
        stream(DEPTH, 1, 8'h7F);
        wait_idle();
        chk("t7_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("t7_ff", got_q[0], FF_PROD);
            chk("t7_min", got_q[1], MIN_DOT);
        end

        // Randomized weights, activations, gaps and backpressure
        for (int r = 0; r < 6; r++) begin
            bp_mode = 1;
            gaps    = 1'b1;
            init(1'($urandom));
            stream(DEPTH, 2, 8'd0);
            stream($urandom_range(10, 40), 2, 8'd0);
            wait_idle();
            gaps    = 1'b0;
            bp_mode = 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
